// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline stages.
// Holds the MEM-stage FSM encoding and the write-back bubble value.
package riscv_pkg;

   localparam int WB_CTL_W   = 2;
   localparam int REG_ADDR_W = 5;

   localparam logic [WB_CTL_W-1:0] WB_CTL_BUBBLE = '0;

   typedef enum logic {
      MEM_IDLE,
      MEM_WAIT
   } mem_state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog counter for outstanding data-memory accesses.
// Expires on the LIMIT-th consecutive enabled cycle after a clear.
module mem_timeout_counter #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory handshake, branch resolve, MEM/WB register.
// Define MEM_ACCESS_TIMEOUT_EN to enable the access watchdog and mem_fault.
module mem_access_stage
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid,
   input  logic [WB_CTL_W-1:0]   wb_ctl,
   input  logic                  branch,
   input  logic                  memread,
   input  logic                  memwrite,
   input  logic                  zero,
   input  logic [31:0]           add_result,
   input  logic [31:0]           alu_result,
   input  logic [31:0]           rdata2,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [31:0]           dmem_addr,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_ready,
   input  logic [31:0]           dmem_rdata,
   output logic                  stall,
   output logic                  pcsrc,
   output logic [31:0]           branch_target,
   output logic                  wb_valid,
   output logic [WB_CTL_W-1:0]   wb_ctl_out,
   output logic [31:0]           read_data,
   output logic [31:0]           alu_result_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  mem_fault
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   mem_state_e state, next_state;

   logic access;
   logic in_wait;
   logic expired;
   logic done;

`ifdef MEM_ACCESS_TIMEOUT_EN
   mem_timeout_counter #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (!in_wait && access),
      .enable  (in_wait && !dmem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_fault <= 1'b0;
      end else if (in_wait && expired) begin
         mem_fault <= 1'b1;
      end
   end
`else
   assign expired   = 1'b0;
   assign mem_fault = 1'b0;
`endif

   assign access        = valid && (memread || memwrite);
   assign in_wait       = (state == MEM_WAIT);
   assign pcsrc         = valid && branch && zero;
   assign branch_target = add_result;

   always_comb begin
      next_state = state;
      done       = 1'b0;
      stall      = 1'b0;
      unique case (state)
         MEM_IDLE: begin
            stall = access;
            if (access) next_state = MEM_WAIT;
         end
         MEM_WAIT: begin
            done  = dmem_ready || expired;
            stall = !done;
            if (done) next_state = MEM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MEM_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Request fields are captured once and held stable for the whole WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else if (!in_wait && access) begin
         dmem_req   <= 1'b1;
         dmem_we    <= memwrite;
         dmem_addr  <= alu_result;
         dmem_wdata <= rdata2;
      end else if (done) begin
         dmem_req   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid       <= 1'b0;
         wb_ctl_out     <= WB_CTL_BUBBLE;
         read_data      <= '0;
         alu_result_out <= '0;
         rd_out         <= '0;
      end else begin
         // Timed-out loads return zero rather than whatever is on the bus.
         read_data <= (done && !dmem_we && dmem_ready) ? dmem_rdata : '0;
         if (stall) begin
            wb_valid   <= 1'b0;
            wb_ctl_out <= WB_CTL_BUBBLE;
         end else begin
            wb_valid       <= valid;
            wb_ctl_out     <= wb_ctl;
            alu_result_out <= alu_result;
            rd_out         <= rd;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Watchdog steps run only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [1:0]  wb_ctl;
   logic        branch, memread, memwrite, zero;
   logic [31:0] add_result, alu_result, rdata2;
   logic [4:0]  rd;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        stall, pcsrc;
   logic [31:0] branch_target;
   logic        wb_valid;
   logic [1:0]  wb_ctl_out;
   logic [31:0] read_data, alu_result_out;
   logic [4:0]  rd_out;
   logic        mem_fault;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mem_access_stage #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .valid          (valid),
      .wb_ctl         (wb_ctl),
      .branch         (branch),
      .memread        (memread),
      .memwrite       (memwrite),
      .zero           (zero),
      .add_result     (add_result),
      .alu_result     (alu_result),
      .rdata2         (rdata2),
      .rd             (rd),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_ready     (dmem_ready),
      .dmem_rdata     (dmem_rdata),
      .stall          (stall),
      .pcsrc          (pcsrc),
      .branch_target  (branch_target),
      .wb_valid       (wb_valid),
      .wb_ctl_out     (wb_ctl_out),
      .read_data      (read_data),
      .alu_result_out (alu_result_out),
      .rd_out         (rd_out),
      .mem_fault      (mem_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid = 0; wb_ctl = 0; branch = 0; memread = 0; memwrite = 0;
      zero = 0; add_result = 0; alu_result = 0; rdata2 = 0; rd = 0;
      dmem_ready = 0; dmem_rdata = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      step(); step();
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wbv", 32'(wb_valid), 0);
      chk("rst_rdata", read_data, 0);
      chk("rst_alu", alu_result_out, 0);
      chk("rst_fault", 32'(mem_fault), 0);
      reset = 0;
      step();

      // ALU pass-through
      valid = 1; alu_result = 32'h1234; rd = 5; wb_ctl = 2'b10;
      #1 chk("alu_stall", 32'(stall), 0);
      step();
      chk("alu_wbv", 32'(wb_valid), 1);
      chk("alu_res", alu_result_out, 32'h1234);
      chk("alu_rd", 32'(rd_out), 5);
      chk("alu_ctl", 32'(wb_ctl_out), 2);
      chk("alu_req", 32'(dmem_req), 0);
      idle_inputs();
      step();
      chk("inv_wbv", 32'(wb_valid), 0);

      // Load, ready on the third WAIT cycle (T+3)
      valid = 1; memread = 1; alu_result = 32'h100; rd = 7; wb_ctl = 2'b11;
      #1 chk("ld_stall_t0", 32'(stall), 1);
      chk("ld_req_t0", 32'(dmem_req), 0);
      step();
      chk("ld_req_t1", 32'(dmem_req), 1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", 32'(dmem_we), 0);
      chk("ld_stall_t1", 32'(stall), 1);
      chk("ld_bub_t1", 32'(wb_valid), 0);
      step();
      chk("ld_stall_t2", 32'(stall), 1);
      chk("ld_bub_t2", 32'(wb_valid), 0);
      chk("ld_bubctl", 32'(wb_ctl_out), 0);
      step();
      chk("ld_bub_t3", 32'(wb_valid), 0);
      dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
      #1 chk("ld_stall_t3", 32'(stall), 0);
      step();
      chk("ld_rdata", read_data, 32'hDEADBEEF);
      chk("ld_wbv", 32'(wb_valid), 1);
      chk("ld_rd", 32'(rd_out), 7);
      chk("ld_ctl", 32'(wb_ctl_out), 3);
      chk("ld_req_done", 32'(dmem_req), 0);
      idle_inputs();
      step();
      chk("ld_rdata_clr", read_data, 0);

      // Store, ready on first request cycle
      valid = 1; memwrite = 1; alu_result = 32'h200;
      rdata2 = 32'hCAFEF00D; rd = 0; wb_ctl = 2'b01;
      #1 chk("st_stall_t0", 32'(stall), 1);
      step();
      chk("st_req", 32'(dmem_req), 1);
      chk("st_we", 32'(dmem_we), 1);
      chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
      chk("st_addr", dmem_addr, 32'h200);
      dmem_ready = 1; dmem_rdata = 32'h99999999;
      #1 chk("st_stall_t1", 32'(stall), 0);
      step();
      chk("st_wbv", 32'(wb_valid), 1);
      chk("st_rdata", read_data, 0);
      chk("st_req_done", 32'(dmem_req), 0);
      idle_inputs();
      step();

      // memread and memwrite both set: treated as store
      valid = 1; memread = 1; memwrite = 1; alu_result = 32'h204;
      rdata2 = 32'h0000ABCD;
      step();
      chk("rw_we", 32'(dmem_we), 1);
      dmem_ready = 1; dmem_rdata = 32'h55555555;
      step();
      chk("rw_rdata", read_data, 0);
      idle_inputs();
      step();

      // Branch resolve
      valid = 1; branch = 1; zero = 1; add_result = 32'h40;
      #1 chk("br_pcsrc", 32'(pcsrc), 1);
      chk("br_target", branch_target, 32'h40);
      chk("br_stall", 32'(stall), 0);
      zero = 0;
      #1 chk("br_nt", 32'(pcsrc), 0);
      valid = 0; zero = 1;
      #1 chk("br_inv", 32'(pcsrc), 0);
      idle_inputs();
      step();

      // Reset during WAIT abandons the access
      valid = 1; memread = 1; alu_result = 32'h300; rd = 9; wb_ctl = 2'b10;
      step();
      chk("rw_req_set", 32'(dmem_req), 1);
      reset = 1;
      step();
      chk("rwait_req", 32'(dmem_req), 0);
      chk("rwait_addr", dmem_addr, 0);
      chk("rwait_wbv", 32'(wb_valid), 0);
      chk("rwait_rd", 32'(rd_out), 0);
      chk("rwait_alu", alu_result_out, 0);
      reset = 0;
      #1 chk("rwait_stall", 32'(stall), 1);
      step();
      chk("rwait_reissue", 32'(dmem_req), 1);
      chk("rwait_raddr", dmem_addr, 32'h300);
      dmem_ready = 1; dmem_rdata = 32'h11112222;
      step();
      chk("rwait_rdata", read_data, 32'h11112222);
      chk("rwait_rdv", 32'(rd_out), 9);
      idle_inputs();
      step();

`ifdef MEM_ACCESS_TIMEOUT_EN
      // Watchdog: memory never answers
      valid = 1; memread = 1; alu_result = 32'h400; rd = 3; wb_ctl = 2'b11;
      step();
      chk("to_w1", 32'(stall), 1);
      step();
      chk("to_w2", 32'(stall), 1);
      step();
      chk("to_w3", 32'(stall), 1);
      step();
      chk("to_w4", 32'(stall), 0);
      dmem_rdata = 32'h77777777;
      step();
      chk("to_req", 32'(dmem_req), 0);
      chk("to_fault", 32'(mem_fault), 1);
      chk("to_rdata", read_data, 0);
      chk("to_wbv", 32'(wb_valid), 1);
      idle_inputs();
      step(); step();
      chk("to_sticky", 32'(mem_fault), 1);
      reset = 1;
      step();
      chk("to_clr", 32'(mem_fault), 0);
      reset = 0;
      step();
`else
      chk("nofault", 32'(mem_fault), 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
